// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The header is a little-endian word count of HDR_BYTES bytes.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE
   } loader_state_e;

   localparam int HDR_BYTES = 2;
   localparam int BYTE_W    = 8;

   // Lane index width; a single-lane word still gets a 1-bit index.
   function automatic int lane_bits(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte-lane packer: drops each loaded byte into its lane of a word register.
// The word output already includes the byte being loaded this cycle.
module word_assembler
   import loader_pkg::*;
#(
   parameter int Width = 32,
   parameter int LaneW = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [LaneW-1:0] lane,
   input  logic [7:0]       byte_in,
   output logic [Width-1:0] word
);

   localparam int LANES = Width / BYTE_W;

   logic [Width-1:0] word_reg;
   logic [Width-1:0] word_next;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign word_next[gi*BYTE_W +: BYTE_W] =
            (load && (lane == LaneW'(gi))) ? byte_in : word_reg[gi*BYTE_W +: BYTE_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word_reg <= '0;
      end else if (load) begin
         word_reg <= word_next;
      end
   end

   assign word = word_next;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory, one word per
// write strobe, while holding the core in reset.
module imem_loader
   import loader_pkg::*;
#(
   parameter int Width     = 32,
   parameter int Depth     = 32,
   parameter int AddrWidth = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 wr_en,
   output logic [AddrWidth-1:0] wr_addr,
   output logic [Width-1:0]     wr_data,
   output logic                 busy,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 err
);

   localparam int LANES  = Width / BYTE_W;
   localparam int LANE_W = lane_bits(LANES);
   localparam int IDX_W  = $clog2(Depth + 1);
   localparam int LEN_W  = HDR_BYTES * BYTE_W;

   if ((Width % BYTE_W) != 0 || Depth < 1 || Depth > 65535 ||
       (AddrWidth < 31 && Depth > (1 << AddrWidth))) begin : g_param_check
      $error("imem_loader: Width must be a multiple of 8 and Depth must fit the address space");
   end

   loader_state_e        state_reg, state_next;
   logic [LEN_W-1:0]     len_reg, len_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [LANE_W-1:0]    lane_reg, lane_next;
   logic                 in_ready_reg, in_ready_next;
   logic                 wr_en_reg, wr_en_next;
   logic [AddrWidth-1:0] wr_addr_reg, wr_addr_next;
   logic [Width-1:0]     wr_data_reg, wr_data_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic                 err_reg, err_next;

   logic             xfer;
   logic             asm_load;
   logic             asm_clear;
   logic [Width-1:0] asm_word;
   logic [LEN_W-1:0] hdr_len;

   assign xfer     = in_valid & in_ready_reg;
   assign asm_load = (state_reg == DATA) && xfer;
   assign hdr_len  = {in_data, len_reg[7:0]};

   word_assembler #(
      .Width (Width),
      .LaneW (LANE_W)
   ) u_word_assembler (
      .clk     (clk),
      .reset   (reset),
      .clear   (asm_clear),
      .load    (asm_load),
      .lane    (lane_reg),
      .byte_in (in_data),
      .word    (asm_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         len_reg      <= '0;
         idx_reg      <= '0;
         lane_reg     <= '0;
         in_ready_reg <= 1'b0;
         wr_en_reg    <= 1'b0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         idx_reg      <= idx_next;
         lane_reg     <= lane_next;
         in_ready_reg <= in_ready_next;
         wr_en_reg    <= wr_en_next;
         wr_addr_reg  <= wr_addr_next;
         wr_data_reg  <= wr_data_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
      end
   end

   // Registered outputs are derived from the next state so they line up with it.
   always_comb begin
      state_next   = state_reg;
      len_next     = len_reg;
      idx_next     = idx_reg;
      lane_next    = lane_reg;
      wr_en_next   = 1'b0;
      wr_addr_next = wr_addr_reg;
      wr_data_next = wr_data_reg;
      done_next    = done_reg;
      err_next     = err_reg;
      asm_clear    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = LEN_LO;
               done_next  = 1'b0;
               err_next   = 1'b0;
               len_next   = '0;
               idx_next   = '0;
               lane_next  = '0;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_next   = {len_reg[LEN_W-1:8], in_data};
               state_next = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               len_next = hdr_len;
               if (hdr_len > LEN_W'(Depth)) begin
                  state_next = IDLE;
                  err_next   = 1'b1;
               end else if (hdr_len == '0) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = DATA;
                  idx_next   = '0;
                  lane_next  = '0;
                  asm_clear  = 1'b1;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               if (lane_reg == LANE_W'(LANES - 1)) begin
                  state_next   = WRITE;
                  wr_en_next   = 1'b1;
                  wr_addr_next = AddrWidth'(idx_reg);
                  wr_data_next = asm_word;
                  lane_next    = '0;
               end else begin
                  lane_next = lane_reg + 1'b1;
               end
            end
         end
         WRITE: begin
            asm_clear = 1'b1;
            idx_next  = idx_reg + 1'b1;
            if ((LEN_W'(idx_reg) + LEN_W'(1)) == len_reg) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else begin
               state_next = DATA;
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next     = (state_next != IDLE);
      in_ready_next = (state_next == LEN_LO) || (state_next == LEN_HI) || (state_next == DATA);
   end

   assign in_ready = in_ready_reg;
   assign wr_en    = wr_en_reg;
   assign wr_addr  = wr_addr_reg;
   assign wr_data  = wr_data_reg;
   assign busy     = busy_reg;
   assign cpu_hold = busy_reg;
   assign done     = done_reg;
   assign err      = err_reg;

endmodule
